// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU, the debug/loader port, the arbiter and the single-port memory.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_done;
  logic              cpu_stall;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_done;
  logic              dbg_halt;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_done, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_halt,
    output dbg_rdata, dbg_done,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_done, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_halt,
    input  dbg_rdata, dbg_done,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the unified memory port between the multicycle CPU and the
// debug/loader port; dbg_halt blocks new CPU grants so the loader can own memory.
module mem_port_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  mem_port_arbiter_if.slave    bus
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;
  typedef enum logic {OWN_CPU, OWN_DBG} owner_e;

  state_e            state_q;
  owner_e            owner_q;
  owner_e            lastOwner_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              memEn_q;
  logic              memWe_q;
  logic [ADDR_W-1:0] memAddr_q;
  logic [DATA_W-1:0] memWdata_q;
  logic [DATA_W-1:0] cpuRdata_q;
  logic [DATA_W-1:0] dbgRdata_q;
  logic              cpuDone_q;
  logic              dbgDone_q;
  logic              busy_q;

  logic              cpuElig;
  logic              dbgElig;
  logic              grantValid_d;
  owner_e            grantOwner_d;
  logic              grantWe_d;
  logic [ADDR_W-1:0] grantAddr_d;
  logic [DATA_W-1:0] grantWdata_d;

  // On a tie the requester that did not own the previous access wins.
  always_comb begin
    cpuElig      = bus.cpu_req & ~bus.dbg_halt;
    dbgElig      = bus.dbg_req;
    grantValid_d = cpuElig | dbgElig;
    grantOwner_d = OWN_CPU;
    if (cpuElig && dbgElig) begin
      grantOwner_d = (lastOwner_q == OWN_DBG) ? OWN_CPU : OWN_DBG;
    end else if (dbgElig) begin
      grantOwner_d = OWN_DBG;
    end
    grantWe_d    = bus.cpu_we;
    grantAddr_d  = bus.cpu_addr;
    grantWdata_d = bus.cpu_wdata;
    if (grantOwner_d == OWN_DBG) begin
      grantWe_d    = bus.dbg_we;
      grantAddr_d  = bus.dbg_addr;
      grantWdata_d = bus.dbg_wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      lastOwner_q <= OWN_DBG;
      cnt_q       <= '0;
      memEn_q     <= 1'b0;
      memWe_q     <= 1'b0;
      memAddr_q   <= '0;
      memWdata_q  <= '0;
      cpuRdata_q  <= '0;
      dbgRdata_q  <= '0;
      cpuDone_q   <= 1'b0;
      dbgDone_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grantValid_d) begin
            owner_q     <= grantOwner_d;
            lastOwner_q <= grantOwner_d;
            memEn_q     <= 1'b1;
            memWe_q     <= grantWe_d;
            memAddr_q   <= grantAddr_d;
            memWdata_q  <= grantWdata_d;
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        // memWe_q still carries the latched direction during the strobe cycle.
        ISSUE: begin
          memEn_q <= 1'b0;
          memWe_q <= 1'b0;
          if (memWe_q) begin
            cpuDone_q <= (owner_q == OWN_CPU);
            dbgDone_q <= (owner_q == OWN_DBG);
            state_q   <= DONE;
          end else begin
            cnt_q   <= CNT_INIT;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            if (owner_q == OWN_CPU) begin
              cpuRdata_q <= bus.mem_rdata;
              cpuDone_q  <= 1'b1;
            end else begin
              dbgRdata_q <= bus.mem_rdata;
              dbgDone_q  <= 1'b1;
            end
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          cpuDone_q <= 1'b0;
          dbgDone_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_en    = memEn_q;
  assign bus.mem_we    = memWe_q;
  assign bus.mem_addr  = memAddr_q;
  assign bus.mem_wdata = memWdata_q;
  assign bus.cpu_rdata = cpuRdata_q;
  assign bus.dbg_rdata = dbgRdata_q;
  assign bus.cpu_done  = cpuDone_q;
  assign bus.dbg_done  = dbgDone_q;
  assign bus.cpu_stall = bus.cpu_req & ~cpuDone_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed latency/reset/round-robin cases, then random traffic
// checked cycle by cycle against a transaction-level latency model.
module tb_mem_port_arbiter;

  localparam int ADDR_W      = 12;
  localparam int DATA_W      = 16;
  localparam int MEM_LAT     = 2;
  localparam int RAND_CYCLES = 4000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Memory macro: writes on the strobe edge, read data appears MEM_LAT cycles after the strobe.
  logic [DATA_W-1:0] macroMem [4096];
  bit                macroValid [4096];
  logic [DATA_W-1:0] pipe [MEM_LAT];

  function automatic logic [DATA_W-1:0] initVal(input logic [ADDR_W-1:0] a);
    return ({4'h0, a} * 16'h9E37) ^ 16'h5A5A;
  endfunction

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) begin
      macroMem[bus.mem_addr]   <= bus.mem_wdata;
      macroValid[bus.mem_addr] <= 1'b1;
    end
    if (bus.mem_en && !bus.mem_we)
      pipe[0] <= macroValid[bus.mem_addr] ? macroMem[bus.mem_addr] : initVal(bus.mem_addr);
    else
      pipe[0] <= DATA_W'($urandom);
    for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
  end

  assign bus.mem_rdata = pipe[MEM_LAT-1];

  // Reference model state
  logic [DATA_W-1:0] refMem [4096];
  bit                refValid [4096];
  bit                cpuPend, dbgPend, inFlight, ownDbg, weM, lastDbg;
  int                issueAt, doneAt;
  logic [DATA_W-1:0] cpuRdM, dbgRdM, rdVal, wdataM;
  logic [ADDR_W-1:0] memAddrM;
  bit                expCpuDone, expDbgDone;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
    bus.dbg_halt = 1'b0;
  endtask

  task automatic setReq(input bit isDbg, input bit we, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d);
    if (isDbg) begin
      bus.dbg_req = 1'b1; bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = d;
    end else begin
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    end
  endtask

  // Random requesters: hold each request until its done pulse, occasional reset and halt toggles.
  task automatic applyStimulus();
    if (expCpuDone) cpuPend = 1'b0;
    if (expDbgDone) dbgPend = 1'b0;
    rst = ($urandom_range(0, 199) == 0);
    if (rst) begin
      cpuPend = 1'b0;
      dbgPend = 1'b0;
    end
    if ($urandom_range(0, 39) == 0) bus.dbg_halt = ~bus.dbg_halt;
    if (!rst && !cpuPend && $urandom_range(0, 99) < 60) begin
      cpuPend = 1'b1;
      bus.cpu_we    = 1'($urandom_range(0, 1));
      bus.cpu_addr  = {8'h80, 4'($urandom)};
      bus.cpu_wdata = DATA_W'($urandom);
    end
    if (!rst && !dbgPend && $urandom_range(0, 99) < 60) begin
      dbgPend = 1'b1;
      bus.dbg_we    = 1'($urandom_range(0, 1));
      bus.dbg_addr  = {8'h80, 4'($urandom)};
      bus.dbg_wdata = DATA_W'($urandom);
    end
    bus.cpu_req = cpuPend;
    bus.dbg_req = dbgPend;
  endtask

  // Transaction model: a grant in cycle t strobes at t+1 and completes at t+2 (write) or t+2+MEM_LAT (read).
  task automatic modelStep(input int t);
    bit ce, de, win;
    logic [ADDR_W-1:0] a;
    if (rst) begin
      inFlight = 1'b0; cpuRdM = '0; dbgRdM = '0; lastDbg = 1'b1; memAddrM = '0;
    end else if (inFlight) begin
      if (t == doneAt) inFlight = 1'b0;
      else if (!weM && t == doneAt - 1) begin
        if (ownDbg) dbgRdM = rdVal; else cpuRdM = rdVal;
      end
    end else begin
      ce = bus.cpu_req && !bus.dbg_halt;
      de = bus.dbg_req;
      if (ce || de) begin
        win      = (ce && de) ? !lastDbg : de;
        ownDbg   = win;
        lastDbg  = win;
        weM      = win ? bus.dbg_we : bus.cpu_we;
        a        = win ? bus.dbg_addr : bus.cpu_addr;
        wdataM   = win ? bus.dbg_wdata : bus.cpu_wdata;
        inFlight = 1'b1;
        issueAt  = t + 1;
        doneAt   = weM ? t + 2 : t + 2 + MEM_LAT;
        memAddrM = a;
        if (weM) begin
          refMem[a] = wdataM;
          refValid[a] = 1'b1;
        end else begin
          rdVal = refValid[a] ? refMem[a] : initVal(a);
        end
      end
    end
  endtask

  task automatic randomPhase();
    bit expMemEn, expBusy;
    idleInputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cpuPend = 0; dbgPend = 0; inFlight = 0; lastDbg = 1; cpuRdM = '0; dbgRdM = '0; memAddrM = '0;
    for (int t = 0; t < RAND_CYCLES; t++) begin
      expMemEn   = inFlight && t == issueAt;
      expBusy    = inFlight && t >= issueAt && t <= doneAt;
      expCpuDone = inFlight && t == doneAt && !ownDbg;
      expDbgDone = inFlight && t == doneAt && ownDbg;
      checkOutput("r_mem_en", bus.mem_en, expMemEn);
      checkOutput("r_mem_we", bus.mem_we, expMemEn && weM);
      checkOutput("r_busy", bus.busy, expBusy);
      checkOutput("r_cpu_done", bus.cpu_done, expCpuDone);
      checkOutput("r_dbg_done", bus.dbg_done, expDbgDone);
      checkOutput("r_mem_addr", bus.mem_addr, memAddrM);
      checkOutput("r_cpu_rdata", bus.cpu_rdata, cpuRdM);
      checkOutput("r_dbg_rdata", bus.dbg_rdata, dbgRdM);
      if (expMemEn && weM) checkOutput("r_mem_wdata", bus.mem_wdata, wdataM);
      applyStimulus();
      #1;
      checkOutput("r_cpu_stall", bus.cpu_stall, bus.cpu_req && !expCpuDone);
      modelStep(t);
      tick();
    end
  endtask

  initial begin
    int seen;
    idleInputs();
    rst = 1'b1;
    tick();
    tick();
    checkOutput("rst_mem_en", bus.mem_en, 0);
    checkOutput("rst_mem_we", bus.mem_we, 0);
    checkOutput("rst_mem_addr", bus.mem_addr, 0);
    checkOutput("rst_mem_wdata", bus.mem_wdata, 0);
    checkOutput("rst_cpu_done", bus.cpu_done, 0);
    checkOutput("rst_dbg_done", bus.dbg_done, 0);
    checkOutput("rst_cpu_rdata", bus.cpu_rdata, 0);
    checkOutput("rst_dbg_rdata", bus.dbg_rdata, 0);
    checkOutput("rst_busy", bus.busy, 0);
    rst = 1'b0;

    // Loader writes 0xA5C3 to 0x010
    setReq(1, 1, 12'h010, 16'hA5C3);
    tick();
    checkOutput("ld_mem_en", bus.mem_en, 1);
    checkOutput("ld_mem_we", bus.mem_we, 1);
    tick();
    checkOutput("ld_dbg_done", bus.dbg_done, 1);
    idleInputs();
    tick();
    checkOutput("ld_idle_busy", bus.busy, 0);

    // CPU read of 0x010
    setReq(0, 0, 12'h010, 16'h0);
    tick();
    checkOutput("rd_mem_en", bus.mem_en, 1);
    checkOutput("rd_mem_we", bus.mem_we, 0);
    checkOutput("rd_mem_addr", bus.mem_addr, 12'h010);
    checkOutput("rd_busy", bus.busy, 1);
    checkOutput("rd_stall", bus.cpu_stall, 1);
    for (int c = 2; c < 2 + MEM_LAT; c++) begin
      tick();
      checkOutput("rd_early_done", bus.cpu_done, 0);
    end
    tick();
    checkOutput("rd_cpu_done", bus.cpu_done, 1);
    checkOutput("rd_cpu_rdata", bus.cpu_rdata, 16'hA5C3);
    checkOutput("rd_stall_done", bus.cpu_stall, 0);
    checkOutput("rd_dbg_done", bus.dbg_done, 0);
    idleInputs();
    tick();
    checkOutput("rd_done_pulse", bus.cpu_done, 0);
    checkOutput("rd_busy_end", bus.busy, 0);
    checkOutput("rd_rdata_hold", bus.cpu_rdata, 16'hA5C3);

    // CPU write 0x0FF=0x1234, then loader reads it back
    setReq(0, 1, 12'h0FF, 16'h1234);
    tick();
    checkOutput("wr_mem_en", bus.mem_en, 1);
    checkOutput("wr_mem_we", bus.mem_we, 1);
    checkOutput("wr_mem_addr", bus.mem_addr, 12'h0FF);
    checkOutput("wr_mem_wdata", bus.mem_wdata, 16'h1234);
    tick();
    checkOutput("wr_cpu_done", bus.cpu_done, 1);
    idleInputs();
    tick();
    setReq(1, 0, 12'h0FF, 16'h0);
    tick();
    repeat (MEM_LAT) tick();
    checkOutput("dbgrd_early", bus.dbg_done, 0);
    tick();
    checkOutput("dbgrd_done", bus.dbg_done, 1);
    checkOutput("dbgrd_rdata", bus.dbg_rdata, 16'h1234);
    checkOutput("dbgrd_cpu_keep", bus.cpu_rdata, 16'hA5C3);
    idleInputs();
    tick();

    // Reset during the WAIT of a CPU read, request held through it
    setReq(0, 0, 12'h0FF, 16'h0);
    tick();
    checkOutput("abort_mem_en", bus.mem_en, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort_busy", bus.busy, 0);
    checkOutput("abort_mem_en0", bus.mem_en, 0);
    checkOutput("abort_cpu_done", bus.cpu_done, 0);
    checkOutput("abort_rdata", bus.cpu_rdata, 0);
    tick();
    checkOutput("retry_mem_en", bus.mem_en, 1);
    repeat (MEM_LAT) tick();
    checkOutput("retry_early", bus.cpu_done, 0);
    tick();
    checkOutput("retry_done", bus.cpu_done, 1);
    checkOutput("retry_rdata", bus.cpu_rdata, 16'h1234);
    idleInputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Both requesters held from reset: CPU first, then strict alternation
    setReq(0, 0, 12'h010, 16'h0);
    setReq(1, 0, 12'h0FF, 16'h0);
    seen = 0;
    for (int c = 0; c < 4 * (3 + MEM_LAT); c++) begin
      tick();
      if (bus.cpu_done || bus.dbg_done) begin
        checkOutput("rr_owner", bus.dbg_done, 32'(seen % 2));
        checkOutput("rr_onehot", bus.cpu_done && bus.dbg_done, 0);
        if (bus.cpu_done) checkOutput("rr_cpu_rdata", bus.cpu_rdata, 16'hA5C3);
        else              checkOutput("rr_dbg_rdata", bus.dbg_rdata, 16'h1234);
        seen++;
      end
    end
    checkOutput("rr_count", seen, 4);

    randomPhase();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
